// File: rtl/counter_pkg.sv
// Shared types and next-value arithmetic for the parametrised event/timing counter.
// All arithmetic is CNT_MAX_WIDTH+1 bits wide so MAX_VAL = 2**WIDTH-1 never wraps silently.
package counter_pkg;

  localparam int unsigned CNT_MAX_WIDTH = 32;

  typedef enum logic {CNT_WRAP, CNT_SAT} cnt_mode_e;

  typedef logic [CNT_MAX_WIDTH:0] cnt_ext_t;

  typedef struct packed {
    cnt_ext_t value;
    logic     boundary;
  } cnt_step_t;

  localparam cnt_ext_t CNT_ONE = cnt_ext_t'(1);

  function automatic cnt_ext_t cnt_clamp(input cnt_ext_t val, input cnt_ext_t max);
    return (val > max) ? max : val;
  endfunction

  // One enabled step; boundary marks a step attempted at the bound in the current direction.
  function automatic cnt_step_t cnt_step(input cnt_ext_t cur, input cnt_ext_t max,
                                         input logic up, input cnt_mode_e mode);
    cnt_step_t r;
    r.boundary = up ? (cur == max) : (cur == '0);
    if (!r.boundary)        r.value = up ? (cur + CNT_ONE) : (cur - CNT_ONE);
    else if (mode == CNT_SAT) r.value = cur;
    else                    r.value = up ? '0 : max;
    return r;
  endfunction

endpackage

// File: rtl/param_counter.sv
// Parametrised up/down counter with load, enable, wrap/saturate, tc pulse and sticky ovf.
// Successor to the fixed 4-bit free-running counter.
module param_counter
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH    = 4,
  parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  localparam longint unsigned RANGE_TOP = (64'd1 << WIDTH) - 64'd1;
  localparam cnt_mode_e       MODE      = SATURATE ? CNT_SAT : CNT_WRAP;
  localparam cnt_ext_t        MAX_EXT   = MAX_VAL[CNT_MAX_WIDTH:0];

  if (WIDTH < 1 || WIDTH > CNT_MAX_WIDTH) begin : g_bad_width
    $fatal(1, "param_counter: WIDTH must be 1..32");
  end
  if (MAX_VAL == 0 || MAX_VAL > RANGE_TOP) begin : g_bad_max
    $fatal(1, "param_counter: MAX_VAL must satisfy 1 <= MAX_VAL <= 2**WIDTH-1");
  end

  cnt_ext_t         cur_ext;
  cnt_ext_t         load_ext;
  cnt_ext_t         load_clamped;
  cnt_step_t        step;
  logic [WIDTH-1:0] count_next;
  logic             tc_next;
  logic             ovf_next;

  always_comb begin
    cur_ext               = '0;
    cur_ext[WIDTH-1:0]    = count;
    load_ext              = '0;
    load_ext[WIDTH-1:0]   = load_val;
    load_clamped          = cnt_clamp(load_ext, MAX_EXT);
    step                  = cnt_step(cur_ext, MAX_EXT, up_dn, MODE);
    count_next            = count;
    tc_next               = 1'b0;
    ovf_next              = ovf & ~clr_ovf;
    if (load) begin
      count_next = load_clamped[WIDTH-1:0];
    end else if (en) begin
      count_next = step.value[WIDTH-1:0];
      // A boundary set beats a same-edge clear.
      if (step.boundary) begin
        tc_next  = 1'b1;
        ovf_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      count <= count_next;
      tc    <= tc_next;
      ovf   <= ovf_next;
    end
  end

endmodule

// File: tb/tb_param_counter.sv
// Bench for param_counter: three configurations share one stimulus stream and are
// compared against an arithmetic reference model (modulo for wrap, min/max for saturate).
module tb_param_counter;
  import counter_pkg::*;

  logic       clk = 1'b0;
  logic       rst, en, up_dn, load, clr_ovf;
  logic [3:0] load_val;
  logic [3:0] cnt_o [3];
  logic       tc_o  [3];
  logic       ovf_o [3];

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model state, one entry per instance.
  int unsigned m_max [3] = '{9, 9, 15};
  bit          m_sat [3] = '{1'b0, 1'b1, 1'b0};
  int unsigned m_cnt [3];
  bit          m_tc  [3];
  bit          m_ovf [3];

  always #5 clk = ~clk;

  param_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .clr_ovf(clr_ovf), .count(cnt_o[0]), .tc(tc_o[0]), .ovf(ovf_o[0]));

  param_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .clr_ovf(clr_ovf), .count(cnt_o[1]), .tc(tc_o[1]), .ovf(ovf_o[1]));

  param_counter #(.WIDTH(4), .MAX_VAL(15), .SATURATE(1'b0)) u_full (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .clr_ovf(clr_ovf), .count(cnt_o[2]), .tc(tc_o[2]), .ovf(ovf_o[2]));

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      bit bnd;
      int signed c;
      c = int'(m_cnt[i]);
      if (rst) begin
        m_cnt[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
      end else if (load) begin
        m_cnt[i] = (int'(load_val) > int'(m_max[i])) ? m_max[i] : int'(load_val);
        m_tc[i]  = 0;
        m_ovf[i] = m_ovf[i] && !clr_ovf;
      end else if (en) begin
        bnd = up_dn ? (m_cnt[i] == m_max[i]) : (m_cnt[i] == 0);
        if (m_sat[i]) begin
          c = up_dn ? c + 1 : c - 1;
          if (c < 0) c = 0;
          if (c > int'(m_max[i])) c = int'(m_max[i]);
          m_cnt[i] = c;
        end else begin
          m_cnt[i] = up_dn ? (m_cnt[i] + 1) % (m_max[i] + 1)
                           : (m_cnt[i] + m_max[i]) % (m_max[i] + 1);
        end
        m_tc[i]  = bnd;
        m_ovf[i] = bnd || (m_ovf[i] && !clr_ovf);
      end else begin
        m_tc[i]  = 0;
        m_ovf[i] = m_ovf[i] && !clr_ovf;
      end
    end
  endtask

  task automatic step(input string tag, input logic r, input logic l, input logic e,
                      input logic u, input logic [3:0] lv, input logic c);
    rst = r; load = l; en = e; up_dn = u; load_val = lv; clr_ovf = c;
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s[%0d].count", tag, i), int'(cnt_o[i]), m_cnt[i]);
      chk($sformatf("%s[%0d].tc", tag, i), int'(tc_o[i]), int'(m_tc[i]));
      chk($sformatf("%s[%0d].ovf", tag, i), int'(ovf_o[i]), int'(m_ovf[i]));
    end
  endtask

  initial begin
    rst = 1'b0; load = 1'b0; en = 1'b0; up_dn = 1'b0; load_val = '0; clr_ovf = 1'b0;
    for (int i = 0; i < 3; i++) begin m_cnt[i] = 0; m_tc[i] = 0; m_ovf[i] = 0; end
    @(negedge clk);

    // Reset held two edges with en active, then the first enabled edge counts to 1.
    step("reset", 1, 0, 1, 1, 4'd0, 0);
    step("reset", 1, 0, 1, 1, 4'd0, 0);
    chk("reset_count", int'(cnt_o[0]), 0);
    step("release", 0, 0, 1, 1, 4'd0, 0);
    chk("release_count", int'(cnt_o[0]), 1);

    // Wrap up from 0 for 12 edges.
    step("rst0", 1, 0, 0, 1, 4'd0, 0);
    for (int k = 0; k < 12; k++) step("wrap_up", 0, 0, 1, 1, 4'd0, 0);
    chk("wrap_end_count", int'(cnt_o[0]), 2);
    chk("wrap_end_ovf", int'(ovf_o[0]), 1);

    // Saturating count down from 2.
    step("load2", 0, 1, 0, 0, 4'd2, 0);
    for (int k = 0; k < 5; k++) step("sat_down", 0, 0, 1, 0, 4'd0, 0);
    chk("sat_down_count", int'(cnt_o[1]), 0);
    chk("sat_down_tc", int'(tc_o[1]), 1);

    // Load beats enable and clamps to MAX_VAL, then wrap with tc.
    step("load_clamp", 0, 1, 1, 1, 4'd13, 0);
    chk("load_clamp_count", int'(cnt_o[0]), 9);
    chk("load_clamp_tc", int'(tc_o[0]), 0);
    step("after_clamp", 0, 0, 1, 1, 4'd0, 0);
    chk("after_clamp_tc", int'(tc_o[0]), 1);

    // Clear racing a boundary event, then a lone clear.
    step("load9", 0, 1, 0, 1, 4'd9, 0);
    step("clr_race", 0, 0, 1, 1, 4'd0, 1);
    chk("clr_race_ovf", int'(ovf_o[0]), 1);
    step("clr_alone", 0, 0, 0, 1, 4'd0, 1);
    chk("clr_alone_ovf", int'(ovf_o[0]), 0);

    // Reset beats a simultaneous load.
    step("load7", 0, 1, 0, 1, 4'd7, 0);
    step("rst_load", 1, 1, 1, 1, 4'd3, 0);
    chk("rst_load_count", int'(cnt_o[0]), 0);

    // Full-range instance wraps 15 -> 0.
    step("load15", 0, 1, 0, 1, 4'd15, 0);
    step("full_wrap", 0, 0, 1, 1, 4'd0, 0);
    chk("full_wrap_count", int'(cnt_o[2]), 0);
    chk("full_wrap_tc", int'(tc_o[2]), 1);

    // Randomised traffic.
    for (int k = 0; k < 400; k++) begin
      step("rand",
           ($urandom_range(39) == 0),
           ($urandom_range(7) == 0),
           ($urandom_range(3) != 0),
           1'($urandom_range(1)),
           4'($urandom_range(15)),
           ($urandom_range(9) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
